sequenciador_acoes: RTL and testbench
=====================================

Name: sequenciador_acoes

Overview:
- Parametrised successor to the toy's action counter and display path, in one clocked block.
- Steps a toy "action" index through NUM_ACOES states at one of four selectable speeds.
- Supports wrap-around or ping-pong ordering, plus a pushbutton pause/resume toggle.
- Gated by the power switch; multiplexes a 4-digit common-anode 7-segment display showing action index and speed.

Parameters:
- NUM_ACOES, 8: number of action states, legal range 2..16; index width ACAO_W = clog2(NUM_ACOES) is a derived localparam.
- PRESCALE, 6250000: clock_entrada cycles per base tick; minimum 2.
- SCAN_DIV, 2048: clock_entrada cycles per display digit slot; minimum 2.

Ports:
- clock_entrada  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- power  in  1  1 = toy on.
- velocidade  in  2  speed select; 0 slowest, 3 fastest.
- modo  in  1  0 = wrap, 1 = ping-pong.
- botao_n  in  1  raw pushbutton, active-low, asynchronous to clock.
- acao  out  ACAO_W  current action index.
- passo  out  1  one-cycle pulse in the cycle acao takes a new value.
- pausado  out  1  pause state.
- digito_n  out  4  digit enables, active-low, one-hot-low.
- segmentos  out  8  {p,g,f,e,d,c,b,a}, active-low.
- led_vermelho  out  1  equals ~power (combinational).
- led_azul  out  1  equals power (combinational).

Behaviour:
- Reset (async assert, sync release): acao=0, direction=up, pausado=0, passo=0, prescaler=0, tick counter=0, scan index=0, digito_n=4'b1111, segmentos=8'hFF, synchroniser flops=1.
- Button input: 2-FF synchroniser, then edge register. A falling edge of the synchronised botao_n gives a 1-cycle press. Press toggles pausado. Latency is 3 cycles from pin to pausado. No debounce here; debounce is upstream.
- Prescaler: counts 0..PRESCALE-1, emits base tick on terminal count, then wraps. Runs whenever power=1, including while paused.
- Speed: limit L = 8,4,2,1 base ticks for velocidade = 0,1,2,3.
  - A tick counter increments on base ticks while not paused.
  - When a tick arrives and counter >= L-1: generate step, clear counter.
  - velocidade changes do not clear the counter. Switching to a faster speed with counter already >= new L-1 steps on the next base tick.
- Step, wrap mode: acao = (acao == NUM_ACOES-1) ? 0 : acao+1. Direction forced to up.
- Step, ping-pong mode:
  - Going up at NUM_ACOES-1: acao = NUM_ACOES-2, direction down.
  - Going down at 0: acao = 1, direction up.
  - Otherwise: ±1 per direction.
  - Switching modo 1→0 while going down: next step is +1 from the current value.
- passo: registered; high exactly in the cycle acao changes. acao updates 1 cycle after the internal step.
- Simultaneous press and step in the same cycle: the press wins. pausado toggles, no step occurs, tick counter holds.
- Paused: acao, direction and tick counter hold. The display keeps scanning.
- power=0 (synchronous effect next edge):
  - acao=0, direction=up, pausado=0, tick counter=0, prescaler=0, scan index=0.
  - digito_n=4'b1111, segmentos=8'hFF, passo=0.
  - Presses are ignored.
  - On power returning to 1, counting restarts from a full interval.
- Display scan: the slot counter counts 0..SCAN_DIV-1. On terminal count the digit index advances 0→1→2→3→0. digito_n bit k is low only while index=k; all outputs are registered.
  - Digit 0: hex glyph of acao (0-F). Decimal point lit (p=0) when pausado=1.
  - Digit 3: glyph of velocidade (0-3).
  - Digits 1 and 2: enabled in turn but segmentos=8'hFF (blank).
- Hex glyphs: standard active-low; for example 0 = 8'hC0, 1 = 8'hF9, 2 = 8'hA4, 3 = 8'hB0.
- Reset mid-operation: all registers return to reset values immediately, regardless of power.

Test Plan:
- Wrap, max speed: NUM_ACOES=5, PRESCALE=4, velocidade=3, modo=0, power=1. Release reset, run 24 cycles -> acao goes 0,1,2,3,4,0. Steps come every 4 cycles, one passo pulse per change.
- Ping-pong: NUM_ACOES=4, same timing, modo=1 -> acao sequence 1,2,3,2,1,0,1. No repeated value at either end.
- Speed: velocidade=0, PRESCALE=4 -> first step after 32 cycles. Change to velocidade=3 with tick counter at 5 -> step on the next base tick.
- Pause: pulse botao_n low mid-interval -> pausado=1 three cycles later, acao frozen for 100 cycles, digit 0 shows p=0. Press again -> resumes. Drive press coincident with step -> no step occurs.
- Power: power=0 with acao=3 and pausado=1 -> next edge gives acao=0, pausado=0, digito_n=1111, segmentos=FF, led_vermelho=1. power=1 -> first step a full interval later.
- Scan: SCAN_DIV=2, acao=2, velocidade=1 -> digito_n cycles 1110,1101,1011,0111 every 2 cycles. segmentos = A4, FF, FF, F9 respectively.

Source files
------------

// File: rtl/sequenciador_acoes_if.sv
// Bus bundle for the action sequencer: toy controls in, action/display/LED state out.
interface sequenciador_acoes_if #(
    parameter int NUM_ACOES = 8
);
    localparam int ACAO_W = $clog2(NUM_ACOES);

    logic              power;
    logic [1:0]        velocidade;
    logic              modo;
    logic              botao_n;
    logic [ACAO_W-1:0] acao;
    logic              passo;
    logic              pausado;
    logic [3:0]        digito_n;
    logic [7:0]        segmentos;
    logic              led_vermelho;
    logic              led_azul;

    modport master (
        output power, velocidade, modo, botao_n,
        input  acao, passo, pausado, digito_n, segmentos, led_vermelho, led_azul
    );

    modport slave (
        input  power, velocidade, modo, botao_n,
        output acao, passo, pausado, digito_n, segmentos, led_vermelho, led_azul
    );
endinterface

// File: rtl/sequenciador_acoes.sv
// Toy action sequencer: steps an action index at a selectable speed with pause,
// wrap/ping-pong ordering, and drives a 4-digit multiplexed 7-segment display.
module sequenciador_acoes #(
    parameter int NUM_ACOES = 8,
    parameter int PRESCALE  = 6250000,
    parameter int SCAN_DIV  = 2048
) (
    input  logic                 clock_entrada,
    input  logic                 reset_n,
    sequenciador_acoes_if.slave  bus
);
    localparam int ACAO_W = $clog2(NUM_ACOES);
    localparam int PRE_W  = $clog2(PRESCALE);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [ACAO_W-1:0] ACAO_MAX = ACAO_W'(NUM_ACOES - 1);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    logic              btn_s1, btn_s2, btn_prev;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ACAO_W-1:0] acao_q, acao_d;
    dir_t              dir_q, dir_d;
    logic              pausado_q, pausado_d;
    logic              passo_q, passo_d;
    logic [SCAN_W-1:0] scnt_q, scnt_d;
    logic [1:0]        dig_q, dig_d;
    logic [3:0]        digito_q, digito_d;
    logic [7:0]        seg_q, seg_d;

    logic       tick, press, step, scan_end;
    logic [2:0] lim_m1;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        case (bus.velocidade)
            2'd0:    lim_m1 = 3'd7;
            2'd1:    lim_m1 = 3'd3;
            2'd2:    lim_m1 = 3'd1;
            default: lim_m1 = 3'd0;
        endcase
    end

    assign tick     = (pre_q == PRE_W'(PRESCALE - 1));
    assign scan_end = (scnt_q == SCAN_W'(SCAN_DIV - 1));
    assign press    = btn_prev & ~btn_s2;

    always_comb begin
        pre_d     = pre_q;
        cnt_d     = cnt_q;
        acao_d    = acao_q;
        dir_d     = dir_q;
        pausado_d = pausado_q;
        scnt_d    = scnt_q;
        dig_d     = dig_q;
        digito_d  = 4'hF;
        seg_d     = 8'hFF;
        step      = 1'b0;

        if (!bus.power) begin
            pre_d     = '0;
            cnt_d     = '0;
            acao_d    = '0;
            dir_d     = DIR_UP;
            pausado_d = 1'b0;
            scnt_d    = '0;
            dig_d     = '0;
        end else begin
            pre_d = tick ? '0 : pre_q + 1'b1;

            // A press in the same cycle as a due step swallows that step.
            if (press) begin
                pausado_d = ~pausado_q;
            end else if (tick && !pausado_q) begin
                if (cnt_q >= lim_m1) begin
                    cnt_d = '0;
                    step  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            if (step) begin
                if (!bus.modo) begin
                    dir_d  = DIR_UP;
                    acao_d = (acao_q == ACAO_MAX) ? '0 : acao_q + 1'b1;
                end else if (dir_q == DIR_UP) begin
                    if (acao_q == ACAO_MAX) begin
                        acao_d = acao_q - 1'b1;
                        dir_d  = DIR_DOWN;
                    end else begin
                        acao_d = acao_q + 1'b1;
                    end
                end else begin
                    if (acao_q == '0) begin
                        acao_d = ACAO_W'(1);
                        dir_d  = DIR_UP;
                    end else begin
                        acao_d = acao_q - 1'b1;
                    end
                end
            end

            scnt_d = scan_end ? '0 : scnt_q + 1'b1;
            if (scan_end) dig_d = dig_q + 1'b1;

            // Display registers follow next-state values so they line up with the index.
            digito_d = ~(4'b0001 << dig_d);
            case (dig_d)
                2'd0:    seg_d = {~pausado_d, hex7(4'(acao_d))};
                2'd3:    seg_d = {1'b1, hex7({2'b00, bus.velocidade})};
                default: seg_d = 8'hFF;
            endcase
        end
        passo_d = step;
    end

    always_ff @(posedge clock_entrada or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1    <= 1'b1;
            btn_s2    <= 1'b1;
            btn_prev  <= 1'b1;
            pre_q     <= '0;
            cnt_q     <= '0;
            acao_q    <= '0;
            dir_q     <= DIR_UP;
            pausado_q <= 1'b0;
            passo_q   <= 1'b0;
            scnt_q    <= '0;
            dig_q     <= '0;
            digito_q  <= 4'hF;
            seg_q     <= 8'hFF;
        end else begin
            btn_s1    <= bus.botao_n;
            btn_s2    <= btn_s1;
            btn_prev  <= btn_s2;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            acao_q    <= acao_d;
            dir_q     <= dir_d;
            pausado_q <= pausado_d;
            passo_q   <= passo_d;
            scnt_q    <= scnt_d;
            dig_q     <= dig_d;
            digito_q  <= digito_d;
            seg_q     <= seg_d;
        end
    end

    assign bus.acao         = acao_q;
    assign bus.passo        = passo_q;
    assign bus.pausado      = pausado_q;
    assign bus.digito_n     = digito_q;
    assign bus.segmentos    = seg_q;
    assign bus.led_vermelho = ~bus.power;
    assign bus.led_azul     = bus.power;
endmodule

// File: tb/tb_sequenciador_acoes.sv
// Directed bench: wrap (5 actions) and ping-pong (4 actions) sequencers, fast prescale/scan.
module tb_sequenciador_acoes;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sequenciador_acoes_if #(.NUM_ACOES(5)) ia ();
    sequenciador_acoes_if #(.NUM_ACOES(4)) ib ();

    sequenciador_acoes #(.NUM_ACOES(5), .PRESCALE(4), .SCAN_DIV(2)) dut_a (
        .clock_entrada(clk), .reset_n(rst_n), .bus(ia.slave));
    sequenciador_acoes #(.NUM_ACOES(4), .PRESCALE(4), .SCAN_DIV(2)) dut_b (
        .clock_entrada(clk), .reset_n(rst_n), .bus(ib.slave));

    int total = 0;
    int bad   = 0;
    int k     = 0;
    logic [7:0] glyph [0:4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99};
    int         pp    [0:5] = '{0, 1, 2, 3, 2, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        k++;
    endtask

    function automatic logic [3:0] dig_exp(input int d);
        return ~(4'b0001 << d);
    endfunction

    initial begin
        int d;
        logic [7:0] s;
        rst_n = 1'b0;
        ia.power = 1'b1; ia.velocidade = 2'd3; ia.modo = 1'b0; ia.botao_n = 1'b1;
        ib.power = 1'b1; ib.velocidade = 2'd3; ib.modo = 1'b1; ib.botao_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_acao", ia.acao, 0);
        chk("rst_passo", ia.passo, 0);
        chk("rst_pausado", ia.pausado, 0);
        chk("rst_digito", ia.digito_n, 4'hF);
        chk("rst_seg", ia.segmentos, 8'hFF);
        chk("rst_led_verm", ia.led_vermelho, 0);
        chk("rst_led_azul", ia.led_azul, 1);
        rst_n = 1'b1;
        k = 0;

        // Wrap on A, ping-pong on B, display scan on A.
        for (int i = 1; i <= 28; i++) begin
            cyc();
            chk("wrap_acao", ia.acao, (k / 4) % 5);
            chk("wrap_passo", ia.passo, 32'((k % 4) == 0));
            chk("pp_acao", ib.acao, pp[(k / 4) % 6]);
            d = (k / 2) % 4;
            chk("scan_dig", ia.digito_n, dig_exp(d));
            s = (d == 0) ? glyph[(k / 4) % 5] : (d == 3) ? 8'hB0 : 8'hFF;
            chk("scan_seg", ia.segmentos, s);
        end

        // Slowest speed: next step 32 cycles later; B switches to wrap while going down.
        ia.velocidade = 2'd0;
        while (k < 60) begin
            cyc();
            chk("slow_acao", ia.acao, (k < 60) ? 2 : 3);
            chk("slow_passo", ia.passo, 32'(k == 60));
            if (k == 40) begin
                chk("pp_top_turn", ib.acao, 2);
                ib.modo = 1'b0;
            end
            if (k == 44) chk("pp_to_wrap", ib.acao, 3);
            if (k == 48) chk("pp_wrap_end", ib.acao, 0);
        end
        // Tick counter reaches 5 at k=80, then switch to fastest.
        while (k < 84) begin
            cyc();
            if (k == 80) ia.velocidade = 2'd3;
            chk("speedup_acao", ia.acao, (k < 84) ? 3 : 4);
        end

        // Pause: pin low at k=84 -> pausado at k=87.
        ia.botao_n = 1'b0;
        cyc(); cyc();
        chk("pause_lat2", ia.pausado, 0);
        ia.botao_n = 1'b1;
        cyc();
        chk("pause_lat3", ia.pausado, 1);
        while (k < 186) begin
            cyc();
            chk("pause_hold", ia.acao, 4);
            if (((k / 2) % 4) == 0) chk("pause_dp", ia.segmentos, 8'h19);
        end
        ia.botao_n = 1'b0;
        cyc(); cyc();
        chk("resume_lat2", ia.pausado, 1);
        ia.botao_n = 1'b1;
        cyc();
        chk("resume_lat3", ia.pausado, 0);
        cyc(); cyc();
        chk("resume_hold", ia.acao, 4);
        cyc();
        chk("resume_step", ia.acao, 0);
        chk("resume_passo", ia.passo, 1);

        // Press lands in the same cycle as a due step (tick at k=196).
        cyc();
        ia.botao_n = 1'b0;
        cyc(); cyc();
        ia.botao_n = 1'b1;
        cyc();
        chk("coinc_pausado", ia.pausado, 1);
        chk("coinc_acao", ia.acao, 0);
        chk("coinc_passo", ia.passo, 0);
        cyc();
        ia.botao_n = 1'b0;
        cyc(); cyc();
        ia.botao_n = 1'b1;
        cyc();
        chk("unpause", ia.pausado, 0);
        while (k < 212) cyc();
        chk("run_to3", ia.acao, 3);
        ia.botao_n = 1'b0;
        cyc(); cyc();
        ia.botao_n = 1'b1;
        cyc(); cyc();
        chk("pause3_p", ia.pausado, 1);
        chk("pause3_a", ia.acao, 3);

        // Power off, press ignored while off, then power on.
        ia.power = 1'b0;
        cyc();
        chk("off_acao", ia.acao, 0);
        chk("off_pausado", ia.pausado, 0);
        chk("off_digito", ia.digito_n, 4'hF);
        chk("off_seg", ia.segmentos, 8'hFF);
        chk("off_led_verm", ia.led_vermelho, 1);
        chk("off_led_azul", ia.led_azul, 0);
        chk("off_passo", ia.passo, 0);
        cyc();
        ia.botao_n = 1'b0;
        cyc(); cyc(); cyc();
        ia.botao_n = 1'b1;
        cyc();
        chk("off_press_ign", ia.pausado, 0);
        cyc(); cyc();
        chk("off_digito2", ia.digito_n, 4'hF);
        ia.power = 1'b1;
        cyc();
        chk("on_dig0", ia.digito_n, 4'b1110);
        cyc();
        chk("on_dig1", ia.digito_n, 4'b1101);
        cyc();
        chk("on_hold", ia.acao, 0);
        cyc();
        chk("on_step", ia.acao, 1);
        chk("on_passo", ia.passo, 1);

        // Scan contents with acao=2, velocidade=1.
        ia.velocidade = 2'd1;
        while (k < 244) begin
            cyc();
            chk("v1_acao", ia.acao, (k < 244) ? 1 : 2);
        end
        while (k < 252) begin
            d = ((k - 224) / 2) % 4;
            s = (d == 0) ? 8'hA4 : (d == 3) ? 8'hF9 : 8'hFF;
            chk("scan2_dig", ia.digito_n, dig_exp(d));
            chk("scan2_seg", ia.segmentos, s);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
